// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch stage of the multi-cycle MIPS-32 core.
//
// Owns the program counter. On a fetch request from the controller it reads
// one 32-bit word from instruction memory over a req/ready handshake. It
// latches that word into the instruction register and presents the opcode to
// the controller. At the controller's write-back step it commits the next PC.
// The next PC is sequential, a taken branch, or a jump.
//
// Parameters
//   RESET_PC  PC loaded on reset (word aligned)
//   TIMEOUT   max REQ cycles without imem_ready before the sticky error (2..255)
//
// Ports
//   clk, rst_n    clock / asynchronous active-low reset
//   fetch_en      controller fetch-step pulse, starts a fetch
//   pc_update     controller write-back pulse, commits next PC
//   Branch, zero  branch request and ALU zero flag (taken when both set)
//   imem_req      registered memory read request
//   imem_addr     read address (== pc)
//   imem_ready    memory accepts the request; imem_rdata valid in same cycle
//   imem_rdata    instruction word from memory
//   instr         instruction register
//   opCode        instr[31:26], to the controller
//   instr_valid   instr holds the current instruction
//   pc, pc_plus4  current PC and PC + 4 (mod 2^32)
//   fetch_err     sticky memory-timeout flag
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        pc_update,
  input  logic        Branch,
  input  logic        zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opCode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Last counter value before the timeout fires; counting starts at 0 on REQ
  // entry, so exactly TIMEOUT REQ cycles elapse before the error.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        is_jump;

  // Control strobes derived from the current state and inputs
  logic        start_req;
  logic        load_instr;
  logic        cnt_inc;
  logic        timeout_hit;
  logic        commit_pc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (fetch_en) state_next = REQ;
      end
      REQ: begin
        if (imem_ready)                 state_next = HOLD;
        else if (wait_cnt == CNT_LAST)  state_next = ERR;
      end
      HOLD: begin
        // A write-back coinciding with the next fetch step skips IDLE.
        if (pc_update) state_next = fetch_en ? REQ : IDLE;
      end
      ERR: begin
        state_next = ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    start_req   = 1'b0;
    load_instr  = 1'b0;
    cnt_inc     = 1'b0;
    timeout_hit = 1'b0;
    commit_pc   = 1'b0;
    unique case (state)
      IDLE: begin
        start_req = fetch_en;
      end
      REQ: begin
        load_instr  = imem_ready;
        timeout_hit = !imem_ready && (wait_cnt == CNT_LAST);
        cnt_inc     = !imem_ready && (wait_cnt != CNT_LAST);
      end
      HOLD: begin
        commit_pc = pc_update;
        start_req = pc_update && fetch_en;
      end
      ERR: begin
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-PC computation: jump beats branch beats sequential
  // ---------------------------------------------------------------------------
  assign pc_plus4   = pc + 32'd4;
  assign is_jump    = (instr[31:27] == 5'b00001);
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (is_jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (Branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (start_req) begin
        imem_req <= 1'b1;
        wait_cnt <= '0;
      end
      if (load_instr) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
        imem_req    <= 1'b0;
      end
      if (cnt_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout_hit) begin
        imem_req  <= 1'b0;
        fetch_err <= 1'b1;
      end
      if (commit_pc) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = pc;
  assign opCode    = instr[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch. Three instances differ only in RESET_PC, so the
// PC regions needed by the scenarios (low, 0x4000_xxxx, top of memory) are
// reachable. Directed scenarios are followed by a randomized run against a
// behavioural next-PC model.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_en    [3];
  logic        pc_update   [3];
  logic        Branch      [3];
  logic        zero        [3];
  logic        imem_ready  [3];
  logic [31:0] imem_rdata  [3];
  logic        imem_req    [3];
  logic [31:0] imem_addr   [3];
  logic [31:0] instr       [3];
  logic [5:0]  opCode      [3];
  logic        instr_valid [3];
  logic [31:0] pc          [3];
  logic [31:0] pc_plus4    [3];
  logic        fetch_err   [3];

  int n_cmp;
  int n_bad;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_fetch #(
      .RESET_PC((g == 0) ? 32'h0000_0100 : (g == 1) ? 32'h4000_0000 : 32'hFFFF_FFF8),
      .TIMEOUT (16)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_en   (fetch_en[g]),
      .pc_update  (pc_update[g]),
      .Branch     (Branch[g]),
      .zero       (zero[g]),
      .imem_req   (imem_req[g]),
      .imem_addr  (imem_addr[g]),
      .imem_ready (imem_ready[g]),
      .imem_rdata (imem_rdata[g]),
      .instr      (instr[g]),
      .opCode     (opCode[g]),
      .instr_valid(instr_valid[g]),
      .pc         (pc[g]),
      .pc_plus4   (pc_plus4[g]),
      .fetch_err  (fetch_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference next-PC from the instruction-set rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input bit br, input bit z);
    logic [31:0] seq;
    logic [5:0]  op;
    int          off;
    seq = p + 32'd4;
    op  = ins[31:26];
    if (op == 6'd2 || op == 6'd3)
      return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (br && z) begin
      off = $signed(ins[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one fetch on instance i. lat counts edges from the fetch_en edge to
  // instr_valid visible; addr0 is the address in the first REQ cycle; stable
  // stays set only if req and addr held steady for the whole request.
  task automatic do_fetch(input int i, input logic [31:0] word, input int waits, input bit pulse,
                          output int lat, output logic [31:0] addr0, output bit stable);
    stable = 1'b1;
    if (pulse) begin
      fetch_en[i] = 1'b1;
      tick();
      fetch_en[i] = 1'b0;
    end
    lat   = 1;
    addr0 = imem_addr[i];
    imem_rdata[i] = word;
    for (int k = 0; k < 40; k++) begin
      if (imem_req[i] !== 1'b1 || imem_addr[i] !== addr0) stable = 1'b0;
      imem_ready[i] = (k >= waits);
      tick();
      lat++;
      if (instr_valid[i] === 1'b1) break;
    end
    imem_ready[i] = 1'b0;
  endtask

  task automatic commit(input int i, input bit br, input bit z, input bit fe);
    Branch[i]    = br;
    zero[i]      = z;
    pc_update[i] = 1'b1;
    fetch_en[i]  = fe;
    tick();
    pc_update[i] = 1'b0;
    fetch_en[i]  = 1'b0;
    Branch[i]    = 1'b0;
    zero[i]      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_en[i] = 0; pc_update[i] = 0; Branch[i] = 0; zero[i] = 0;
      imem_ready[i] = 0; imem_rdata[i] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (pc[0] !== 32'h100) begin n_bad++; $display("FAIL reset_pc0 got=%h exp=%h", pc[0], 32'h100); end
    n_cmp++; if (pc[1] !== 32'h4000_0000) begin n_bad++; $display("FAIL reset_pc1 got=%h exp=%h", pc[1], 32'h4000_0000); end
    n_cmp++; if (pc_plus4[0] !== 32'h104) begin n_bad++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4[0], 32'h104); end
    n_cmp++; if (imem_addr[0] !== 32'h100) begin n_bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr[0], 32'h100); end
    n_cmp++; if (instr[0] !== 32'h0) begin n_bad++; $display("FAIL reset_instr got=%h exp=0", instr[0]); end
    n_cmp++; if ({imem_req[0], instr_valid[0], fetch_err[0]} !== 3'b000) begin n_bad++;
      $display("FAIL reset_flags got req/valid/err=%b%b%b exp=000", imem_req[0], instr_valid[0], fetch_err[0]); end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] a0; bit st;
    do_fetch(0, 32'h2008_0005, 0, 1'b1, lat, a0, st);
    n_cmp++; if (a0 !== 32'h100) begin n_bad++; $display("FAIL basic_addr got=%h exp=%h", a0, 32'h100); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    n_cmp++; if (opCode[0] !== 6'b001000) begin n_bad++; $display("FAIL basic_opcode got=%b exp=001000", opCode[0]); end
    n_cmp++; if (instr[0] !== 32'h2008_0005) begin n_bad++; $display("FAIL basic_instr got=%h exp=20080005", instr[0]); end
    n_cmp++; if (imem_req[0] !== 1'b0) begin n_bad++; $display("FAIL basic_req_drop got=%b exp=0", imem_req[0]); end
    commit(0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc[0] !== 32'h104) begin n_bad++; $display("FAIL basic_seq_pc got=%h exp=104", pc[0]); end
    n_cmp++; if (instr_valid[0] !== 1'b0) begin n_bad++; $display("FAIL basic_valid_clr got=%b exp=0", instr_valid[0]); end
  endtask

  task automatic test_branch();
    int lat; logic [31:0] a0; bit st;
    do_fetch(0, 32'h0800_0080, 0, 1'b1, lat, a0, st);
    commit(0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc[0] !== 32'h200) begin n_bad++; $display("FAIL branch_setup got=%h exp=200", pc[0]); end
    do_fetch(0, 32'h1000_FFFE, 0, 1'b1, lat, a0, st);
    commit(0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (pc[0] !== 32'h1FC) begin n_bad++; $display("FAIL branch_taken got=%h exp=1fc", pc[0]); end
    do_fetch(0, 32'h0800_0080, 0, 1'b1, lat, a0, st);
    commit(0, 1'b0, 1'b0, 1'b0);
    do_fetch(0, 32'h1000_FFFE, 0, 1'b1, lat, a0, st);
    commit(0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (pc[0] !== 32'h204) begin n_bad++; $display("FAIL branch_not_taken got=%h exp=204", pc[0]); end
  endtask

  task automatic test_jump();
    int lat; logic [31:0] a0; bit st;
    do_fetch(1, 32'h1000_0003, 0, 1'b1, lat, a0, st);
    commit(1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (pc[1] !== 32'h4000_0010) begin n_bad++; $display("FAIL jump_setup got=%h exp=40000010", pc[1]); end
    do_fetch(1, 32'h0800_0040, 0, 1'b1, lat, a0, st);
    commit(1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc[1] !== 32'h4000_0100) begin n_bad++; $display("FAIL jump_j got=%h exp=40000100", pc[1]); end
    do_fetch(1, 32'h0800_0004, 0, 1'b1, lat, a0, st);
    commit(1, 1'b0, 1'b0, 1'b0);
    do_fetch(1, 32'h0C00_0040, 0, 1'b1, lat, a0, st);
    commit(1, 1'b1, 1'b1, 1'b0);   // jump must win over a taken branch
    n_cmp++; if (pc[1] !== 32'h4000_0100) begin n_bad++; $display("FAIL jump_jal got=%h exp=40000100", pc[1]); end
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] a0; bit st;
    do_fetch(0, 32'h2108_0001, 5, 1'b1, lat, a0, st);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL wait_latency got=%0d exp=7", lat); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL wait_addr_stable got=%b exp=1", st); end
    n_cmp++; if (a0 !== 32'h204) begin n_bad++; $display("FAIL wait_addr got=%h exp=204", a0); end
  endtask

  task automatic test_ignored_and_simultaneous();
    int lat; logic [31:0] a0; bit st;
    fetch_en[0] = 1'b1;
    tick();
    fetch_en[0] = 1'b0;
    n_cmp++; if ({instr_valid[0], imem_req[0]} !== 2'b10) begin n_bad++;
      $display("FAIL hold_fetch_ignored got valid/req=%b%b exp=10", instr_valid[0], imem_req[0]); end
    n_cmp++; if (pc[0] !== 32'h204 || instr[0] !== 32'h2108_0001) begin n_bad++;
      $display("FAIL hold_fetch_state got pc=%h instr=%h exp pc=204 instr=21080001", pc[0], instr[0]); end
    commit(0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (imem_req[0] !== 1'b1 || imem_addr[0] !== 32'h208) begin n_bad++;
      $display("FAIL simul_req got req=%b addr=%h exp req=1 addr=208", imem_req[0], imem_addr[0]); end
    n_cmp++; if (instr_valid[0] !== 1'b0) begin n_bad++; $display("FAIL simul_valid got=%b exp=0", instr_valid[0]); end
    do_fetch(0, 32'h0000_0000, 0, 1'b0, lat, a0, st);
    n_cmp++; if (lat !== 2 || a0 !== 32'h208) begin n_bad++;
      $display("FAIL simul_fetch got lat=%0d addr=%h exp lat=2 addr=208", lat, a0); end
    commit(0, 1'b0, 1'b0, 1'b0);
    commit(0, 1'b1, 1'b1, 1'b0);   // IDLE: must be ignored
    n_cmp++; if (pc[0] !== 32'h20C) begin n_bad++; $display("FAIL idle_update got=%h exp=20c", pc[0]); end
    n_cmp++; if ({imem_req[0], instr_valid[0]} !== 2'b00) begin n_bad++;
      $display("FAIL idle_update_flags got req/valid=%b%b exp=00", imem_req[0], instr_valid[0]); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] a0; bit st;
    do_fetch(2, 32'h0000_0000, 0, 1'b1, lat, a0, st);
    commit(2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc[2] !== 32'hFFFF_FFFC || pc_plus4[2] !== 32'h0) begin n_bad++;
      $display("FAIL wrap_setup got pc=%h pc4=%h exp fffffffc/0", pc[2], pc_plus4[2]); end
    do_fetch(2, 32'h0000_0000, 0, 1'b1, lat, a0, st);
    commit(2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc[2] !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got=%h exp=0", pc[2]); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] a0; bit st;
    logic [31:0] mpc, word, exp;
    int waits; bit br, z;
    mpc = 32'h20C;
    for (int it = 0; it < 40; it++) begin
      waits = $urandom_range(0, 4);
      word  = $urandom;
      if ($urandom_range(0, 3) == 0) word[31:27] = 5'b00001;
      else if ($urandom_range(0, 1) == 0) word[31:26] = 6'b000100;
      br = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      do_fetch(0, word, waits, 1'b1, lat, a0, st);
      n_cmp++; if (lat !== waits + 2) begin n_bad++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, waits + 2); end
      n_cmp++; if (a0 !== mpc || st !== 1'b1) begin n_bad++;
        $display("FAIL rand_addr it=%0d got=%h stable=%b exp=%h stable=1", it, a0, st, mpc); end
      n_cmp++; if (instr[0] !== word || opCode[0] !== word[31:26]) begin n_bad++;
        $display("FAIL rand_instr it=%0d got=%h op=%b exp=%h", it, instr[0], opCode[0], word); end
      n_cmp++; if (pc_plus4[0] !== mpc + 32'd4) begin n_bad++; $display("FAIL rand_pc4 it=%0d got=%h exp=%h", it, pc_plus4[0], mpc + 32'd4); end
      exp = ref_next(mpc, word, br, z);
      commit(0, br, z, 1'b0);
      n_cmp++; if (pc[0] !== exp) begin n_bad++; $display("FAIL rand_next_pc it=%0d got=%h exp=%h", it, pc[0], exp); end
      mpc = exp;
    end
  endtask

  task automatic test_timeout();
    int n_req;
    logic [31:0] pc_before;
    pc_before = pc[0];
    fetch_en[0] = 1'b1;
    tick();
    fetch_en[0] = 1'b0;
    n_req = 0;
    for (int k = 0; k < 40; k++) begin
      if (fetch_err[0] === 1'b1) break;
      if (imem_req[0] === 1'b1) n_req++;
      tick();
    end
    n_cmp++; if (fetch_err[0] !== 1'b1 || imem_req[0] !== 1'b0) begin n_bad++;
      $display("FAIL timeout_flag got err=%b req=%b exp err=1 req=0", fetch_err[0], imem_req[0]); end
    n_cmp++; if (n_req !== 16) begin n_bad++; $display("FAIL timeout_cycles got=%0d exp=16", n_req); end
    for (int k = 0; k < 3; k++) begin
      fetch_en[0] = 1'b1; imem_ready[0] = 1'b1;
      tick();
      fetch_en[0] = 1'b0; imem_ready[0] = 1'b0;
      tick();
    end
    commit(0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if ({imem_req[0], instr_valid[0], fetch_err[0]} !== 3'b001 || pc[0] !== pc_before) begin n_bad++;
      $display("FAIL err_terminal got req/valid/err=%b%b%b pc=%h exp 001 pc=%h",
               imem_req[0], instr_valid[0], fetch_err[0], pc[0], pc_before); end
  endtask

  task automatic test_reset_mid_req();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (fetch_err[0] !== 1'b0) begin n_bad++; $display("FAIL reset_clears_err got=%b exp=0", fetch_err[0]); end
    fetch_en[0] = 1'b1;
    tick();
    fetch_en[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req[0] !== 1'b0) begin n_bad++; $display("FAIL async_req_drop got=%b exp=0", imem_req[0]); end
    n_cmp++; if (pc[0] !== 32'h100 || imem_addr[0] !== 32'h100 || pc_plus4[0] !== 32'h104) begin n_bad++;
      $display("FAIL async_pc got pc=%h addr=%h pc4=%h exp 100/100/104", pc[0], imem_addr[0], pc_plus4[0]); end
    n_cmp++; if (instr[0] !== 32'h0 || opCode[0] !== 6'h0 || instr_valid[0] !== 1'b0 || fetch_err[0] !== 1'b0) begin n_bad++;
      $display("FAIL async_regs got instr=%h op=%b valid=%b err=%b exp 0", instr[0], opCode[0], instr_valid[0], fetch_err[0]); end
    n_cmp++; if (pc[1] !== 32'h4000_0000 || pc[2] !== 32'hFFFF_FFF8) begin n_bad++;
      $display("FAIL async_others got pc1=%h pc2=%h exp 40000000/fffffff8", pc[1], pc[2]); end
    tick();
    n_cmp++; if (imem_req[0] !== 1'b0) begin n_bad++; $display("FAIL reset_hold_req got=%b exp=0", imem_req[0]); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_branch();
    test_jump();
    test_wait_states();
    test_ignored_and_simultaneous();
    test_wrap();
    test_random();
    test_timeout();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multi-cycle MIPS-32 processor. It sits directly upstream of the `Control` state machine. It owns the program counter and fetches one 32-bit word per instruction from instruction memory over a request/ready handshake. It holds that word in the instruction register and drives `opCode` to the controller. At the controller's write-back step it commits the next PC: sequential, taken branch, or jump.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- TIMEOUT, 16, maximum cycles spent in REQ waiting for `imem_ready` before flagging an error; valid range 2..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  one-cycle pulse from the controller's fetch step; starts a fetch.
- pc_update  in  1  one-cycle pulse at the controller's write-back step; commits the next PC.
- Branch  in  1  branch request from the controller.
- zero  in  1  ALU zero flag; a branch is taken only when `Branch && zero`.
- imem_req  out  1  memory read request (registered).
- imem_addr  out  32  read address; always equals `pc`.
- imem_ready  in  1  memory accepts the request and `imem_rdata` is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  instruction register.
- opCode  out  6  `instr[31:26]`; drives `Control.opCode`.
- instr_valid  out  1  `instr` holds the current instruction.
- pc  out  32  current PC.
- pc_plus4  out  32  `pc + 4`, combinational, modulo 2^32.
- fetch_err  out  1  sticky memory-timeout flag.

## Operation
- Reset values, applied immediately when `rst_n` goes low:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0
  - imem_req=0, fetch_err=0, wait counter=0
- FSM states: IDLE, REQ, HOLD, ERR.
- IDLE:
  - `fetch_en` → REQ, with `imem_req`←1 and counter←0.
  - `pc_update` is ignored.
- REQ (`imem_req`=1):
  - `imem_ready`=1 → instr←`imem_rdata`, instr_valid←1, imem_req←0, go to HOLD.
  - Otherwise the counter increments.
  - If the counter reaches TIMEOUT−1 without ready → ERR, with imem_req←0 and fetch_err←1.
  - `fetch_en` and `pc_update` are ignored.
- HOLD (`instr_valid`=1; `instr` stable):
  - `pc_update` → pc←next_pc, instr_valid←0, go to IDLE.
  - `pc_update` and `fetch_en` in the same cycle → pc←next_pc, go directly to REQ. `imem_addr` shows the new PC in the first REQ cycle.
  - `fetch_en` alone is ignored.
- ERR: terminal; all inputs are ignored; only reset exits.
- next_pc priority, evaluated from `instr` and the current `pc`:
  - `opCode` = 6'b00001x (j/jal) → {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else `Branch && zero` → pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}, modulo 2^32.
  - else pc_plus4.
- PC arithmetic wraps at 2^32 with no flag. `pc[1:0]` stays 0 by construction.

## Timing
- Fetch latency:
  - `fetch_en` sampled at edge N → `imem_req` high after edge N.
  - `imem_ready` sampled at edge N+1 at the earliest → `instr_valid` high after N+1.
  - Minimum is 2 cycles from `fetch_en` to `instr_valid`.
  - Each wait-state cycle adds 1.
- `imem_addr` is stable for the whole time `imem_req` is high.
- The PC commit takes effect 1 cycle after `pc_update`. `pc` and `pc_plus4` change after that edge.
- `opCode` is stable from `instr_valid` rising until `pc_update` is accepted. This matches the 5-step controller cycle.
- Reset asserted mid-REQ drops `imem_req` asynchronously; the memory must tolerate an abandoned request.

## Test plan
- Reset with RESET_PC=0x100, then `fetch_en` with ready in the first REQ cycle and rdata=0x2008_0005 → `imem_addr`=0x100; `instr_valid` 2 cycles after `fetch_en`; `opCode`=6'b001000. Then `pc_update` with Branch=0 → `pc`=0x104.
- Branch taken: pc=0x200, instr=0x1000_FFFE, Branch=1, zero=1, `pc_update` → pc=0x1FC. Repeat with zero=0 → pc=0x204.
- Jump: pc=0x4000_0010, instr=0x0800_0040, `pc_update` → pc=0x4000_0100. Same with opCode 000011 → same result.
- Wait states and timeout:
  - ready delayed 5 cycles → instr_valid 7 cycles after `fetch_en`; `imem_addr` stable throughout.
  - ready never arrives with TIMEOUT=16 → fetch_err=1 and imem_req=0 after 16 REQ cycles; later `fetch_en` pulses are ignored.
- Simultaneous and ignored events:
  - `pc_update` together with `fetch_en` in HOLD → REQ immediately with imem_addr = new PC.
  - `fetch_en` in HOLD alone → no change.
  - `pc_update` in IDLE → pc unchanged.
- Wrap and reset:
  - pc=0xFFFF_FFFC, sequential `pc_update` → pc=0x0.
  - `rst_n` pulsed low during REQ → imem_req=0 without waiting for a clock edge; all outputs return to reset values.
